// File: rtl/pz_view_generator_pkg.sv
// Shared types for the pole/zero view generator: FSM state encoding and the
// per-pixel sideband flags that travel with each sample point.
package pz_view_generator_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    VIEW_IDLE  = 2'd0,
    VIEW_LATCH = 2'd1,
    VIEW_RUN   = 2'd2
  } view_state_e;

  // Sideband flags accompanying every emitted sample point.
  typedef struct packed {
    logic valid;
    logic sof;
    logic eol;
  } flags_t;

endpackage

// File: rtl/pz_view_generator_cfg_shadow.sv
// Config shadow for the view generator: remembers that a new config was
// offered (pending) and copies it into the frame-stable shadow only when the
// sequencer is in its one-cycle latch state.
module pz_view_generator_cfg_shadow
  import pz_view_generator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PZ     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_update,
  input  logic                           latch,
  input  logic [DATA_WIDTH-1:0]          cfg_origin_re,
  input  logic [DATA_WIDTH-1:0]          cfg_origin_im,
  input  logic [DATA_WIDTH-1:0]          cfg_step,
  input  logic [$clog2(NUM_PZ/2):0]      cfg_num_zeros,
  input  logic [$clog2(NUM_PZ/2):0]      cfg_num_poles,
  input  logic [NUM_PZ*2*DATA_WIDTH-1:0] cfg_pz,
  output logic [DATA_WIDTH-1:0]          origin_re,
  output logic [DATA_WIDTH-1:0]          origin_im,
  output logic [DATA_WIDTH-1:0]          step,
  output logic [DATA_WIDTH-1:0]          origin_re_next,
  output logic [DATA_WIDTH-1:0]          origin_im_next,
  output logic [NUM_PZ*2*DATA_WIDTH-1:0] pz_out,
  output logic [$clog2(NUM_PZ/2):0]      num_zeros_out,
  output logic [$clog2(NUM_PZ/2):0]      num_poles_out
);

  localparam int unsigned CntW = $clog2(NUM_PZ/2) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(NUM_PZ/2);

  logic                           pending_q, pending_d;
  logic                           first_q, first_d;
  logic                           take;
  logic [DATA_WIDTH-1:0]          origin_re_q, origin_re_d;
  logic [DATA_WIDTH-1:0]          origin_im_q, origin_im_d;
  logic [DATA_WIDTH-1:0]          step_q, step_d;
  logic [NUM_PZ*2*DATA_WIDTH-1:0] pz_q, pz_d;
  logic [CntW-1:0]                nz_q, nz_d;
  logic [CntW-1:0]                np_q, np_d;

  function automatic logic [CntW-1:0] clamp_cnt(input logic [CntW-1:0] cnt);
    logic [CntW-1:0] res;
    res = (cnt > MaxCnt) ? MaxCnt : cnt;
    return res;
  endfunction

  // A pulse arriving in the latch cycle itself is consumed by that latch.
  assign take = latch && (pending_q || first_q || cfg_update);

  // Next-state for pending flag and shadow contents.
  always_comb begin
    pending_d   = pending_q;
    first_d     = first_q;
    origin_re_d = origin_re_q;
    origin_im_d = origin_im_q;
    step_d      = step_q;
    pz_d        = pz_q;
    nz_d        = nz_q;
    np_d        = np_q;
    if (latch) begin
      pending_d = 1'b0;
      first_d   = 1'b0;
    end else if (cfg_update) begin
      pending_d = 1'b1;
    end
    if (take) begin
      origin_re_d = cfg_origin_re;
      origin_im_d = cfg_origin_im;
      step_d      = cfg_step;
      pz_d        = cfg_pz;
      nz_d        = clamp_cnt(cfg_num_zeros);
      np_d        = clamp_cnt(cfg_num_poles);
    end
  end

  // Shadow state; first_q forces a load on the first frame after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= 1'b0;
      first_q     <= 1'b1;
      origin_re_q <= '0;
      origin_im_q <= '0;
      step_q      <= '0;
      pz_q        <= '0;
      nz_q        <= '0;
      np_q        <= '0;
    end else begin
      pending_q   <= pending_d;
      first_q     <= first_d;
      origin_re_q <= origin_re_d;
      origin_im_q <= origin_im_d;
      step_q      <= step_d;
      pz_q        <= pz_d;
      nz_q        <= nz_d;
      np_q        <= np_d;
    end
  end

  assign origin_re      = origin_re_q;
  assign origin_im      = origin_im_q;
  assign step           = step_q;
  // Origin that will be in effect after this cycle; lets the sequencer
  // preload the coordinate registers during the latch cycle.
  assign origin_re_next = origin_re_d;
  assign origin_im_next = origin_im_d;
  assign pz_out         = pz_q;
  assign num_zeros_out  = nz_q;
  assign num_poles_out  = np_q;

endmodule

// File: rtl/pz_view_generator.sv
// Pole/zero view generator: walks an X_SIZE x Y_SIZE viewport and emits one
// complex sample point per pixel with valid/ready backpressure. Config is
// shadowed at frame boundaries only.
// Build option: PZ_VIEW_SATURATE_EN makes the coordinate adders saturate
// instead of wrapping.
module pz_view_generator
  import pz_view_generator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned X_SIZE     = 1024,
  parameter int unsigned Y_SIZE     = 1024,
  parameter int unsigned NUM_PZ     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           cfg_update,
  input  logic [DATA_WIDTH-1:0]          cfg_origin_re,
  input  logic [DATA_WIDTH-1:0]          cfg_origin_im,
  input  logic [DATA_WIDTH-1:0]          cfg_step,
  input  logic [$clog2(NUM_PZ/2):0]      cfg_num_zeros,
  input  logic [$clog2(NUM_PZ/2):0]      cfg_num_poles,
  input  logic [NUM_PZ*2*DATA_WIDTH-1:0] cfg_pz,
  output logic [NUM_PZ*2*DATA_WIDTH-1:0] pz_out,
  output logic [$clog2(NUM_PZ/2):0]      num_zeros_out,
  output logic [$clog2(NUM_PZ/2):0]      num_poles_out,
  output logic [DATA_WIDTH-1:0]          coord_re,
  output logic [DATA_WIDTH-1:0]          coord_im,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           sof,
  output logic                           eol,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int unsigned XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] XLast = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] YLast = YW'(Y_SIZE - 1);

`ifdef PZ_VIEW_SATURATE_EN
  localparam logic signed [DATA_WIDTH+1:0] SatMax = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH+1:0] SatMin = {3'b111, {(DATA_WIDTH-1){1'b0}}};
`endif

  view_state_e           state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [DATA_WIDTH-1:0] re_q, re_d;
  logic [DATA_WIDTH-1:0] im_q, im_d;
  logic                  frame_done_q, frame_done_d;
  logic                  latch;
  logic                  x_last, y_last;
  logic [DATA_WIDTH-1:0] re_sum, im_sum;
  logic [DATA_WIDTH-1:0] origin_re, origin_im, step;
  logic [DATA_WIDTH-1:0] origin_re_next, origin_im_next;
  flags_t                flags;

  // Signed coordinate plus/minus unsigned step, two guard bits wide.
  function automatic logic [DATA_WIDTH-1:0] add_step(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] s,
                                                     input logic                  sub);
    logic signed [DATA_WIDTH+1:0] ext_a, ext_s, sum;
    logic [DATA_WIDTH-1:0]        res;
    ext_a = signed'({{2{a[DATA_WIDTH-1]}}, a});
    ext_s = signed'({2'b00, s});
    sum   = sub ? (ext_a - ext_s) : (ext_a + ext_s);
    res   = sum[DATA_WIDTH-1:0];
`ifdef PZ_VIEW_SATURATE_EN
    if (sum > SatMax) begin
      res = SatMax[DATA_WIDTH-1:0];
    end else if (sum < SatMin) begin
      res = SatMin[DATA_WIDTH-1:0];
    end
`endif
    return res;
  endfunction

  pz_view_generator_cfg_shadow #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_PZ     (NUM_PZ)
  ) u_cfg_shadow (
    .clk            (clk),
    .reset          (reset),
    .cfg_update     (cfg_update),
    .latch          (latch),
    .cfg_origin_re  (cfg_origin_re),
    .cfg_origin_im  (cfg_origin_im),
    .cfg_step       (cfg_step),
    .cfg_num_zeros  (cfg_num_zeros),
    .cfg_num_poles  (cfg_num_poles),
    .cfg_pz         (cfg_pz),
    .origin_re      (origin_re),
    .origin_im      (origin_im),
    .step           (step),
    .origin_re_next (origin_re_next),
    .origin_im_next (origin_im_next),
    .pz_out         (pz_out),
    .num_zeros_out  (num_zeros_out),
    .num_poles_out  (num_poles_out)
  );

  assign x_last = (x_q == XLast);
  assign y_last = (y_q == YLast);
  assign re_sum = add_step(re_q, step, 1'b0);
  // Row 0 is the top of the view, so imaginary part decreases per line.
  assign im_sum = add_step(im_q, step, 1'b1);

  // Sequencer next-state: counters and coordinates advance only on transfer.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    re_d         = re_q;
    im_d         = im_q;
    frame_done_d = 1'b0;
    latch        = 1'b0;
    unique case (state_q)
      VIEW_IDLE: begin
        if (enable) begin
          state_d = VIEW_LATCH;
        end
      end
      VIEW_LATCH: begin
        latch   = 1'b1;
        x_d     = '0;
        y_d     = '0;
        re_d    = origin_re_next;
        im_d    = origin_im_next;
        state_d = VIEW_RUN;
      end
      VIEW_RUN: begin
        if (out_ready) begin
          if (x_last) begin
            x_d  = '0;
            re_d = origin_re;
            if (y_last) begin
              y_d          = '0;
              im_d         = origin_im;
              frame_done_d = 1'b1;
              state_d      = enable ? VIEW_LATCH : VIEW_IDLE;
            end else begin
              y_d  = y_q + YW'(1);
              im_d = im_sum;
            end
          end else begin
            x_d  = x_q + XW'(1);
            re_d = re_sum;
          end
        end
      end
      default: begin
        state_d = VIEW_IDLE;
      end
    endcase
  end

  // Sequencer state, pixel counters and coordinate accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= VIEW_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      re_q         <= '0;
      im_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      re_q         <= re_d;
      im_q         <= im_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Sideband flags derive from registered state, so they hold while stalled.
  always_comb begin
    flags.valid = (state_q == VIEW_RUN);
    flags.sof   = flags.valid && (x_q == '0) && (y_q == '0);
    flags.eol   = flags.valid && x_last;
  end

  assign out_valid  = flags.valid;
  assign sof        = flags.sof;
  assign eol        = flags.eol;
  assign coord_re   = re_q;
  assign coord_im   = im_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != VIEW_IDLE);

endmodule

// File: tb/tb_pz_view_generator.sv
// Scoreboard bench for pz_view_generator on a 4x4 frame, 16-bit data.
// Expected coordinates come from origin +/- k*step (clamped when built with
// PZ_VIEW_SATURATE_EN).
module tb_pz_view_generator;

  localparam int DW  = 16;
  localparam int XS  = 4;
  localparam int YS  = 4;
  localparam int NPZ = 16;
  localparam int CW  = $clog2(NPZ/2) + 1;
  localparam int PW  = NPZ * 2 * DW;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sof;
    logic          eol;
    bit            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          cfg_update = 1'b0;
  logic [DW-1:0] cfg_origin_re = '0;
  logic [DW-1:0] cfg_origin_im = '0;
  logic [DW-1:0] cfg_step = '0;
  logic [CW-1:0] cfg_num_zeros = '0;
  logic [CW-1:0] cfg_num_poles = '0;
  logic [PW-1:0] cfg_pz = '0;
  logic [PW-1:0] pz_out;
  logic [CW-1:0] num_zeros_out, num_poles_out;
  logic [DW-1:0] coord_re, coord_im;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          sof, eol, frame_done, busy;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  pz_view_generator #(
    .DATA_WIDTH (DW),
    .X_SIZE     (XS),
    .Y_SIZE     (YS),
    .NUM_PZ     (NPZ)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .cfg_update    (cfg_update),
    .cfg_origin_re (cfg_origin_re),
    .cfg_origin_im (cfg_origin_im),
    .cfg_step      (cfg_step),
    .cfg_num_zeros (cfg_num_zeros),
    .cfg_num_poles (cfg_num_poles),
    .cfg_pz        (cfg_pz),
    .pz_out        (pz_out),
    .num_zeros_out (num_zeros_out),
    .num_poles_out (num_poles_out),
    .coord_re      (coord_re),
    .coord_im      (coord_im),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sof           (sof),
    .eol           (eol),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_coord(input int origin, input int k, input int st,
                                                input bit neg);
    int full;
    full = neg ? (origin - k * st) : (origin + k * st);
`ifdef PZ_VIEW_SATURATE_EN
    if (full > (2 ** (DW - 1)) - 1) full = (2 ** (DW - 1)) - 1;
    if (full < -(2 ** (DW - 1))) full = -(2 ** (DW - 1));
`endif
    return full[DW-1:0];
  endfunction

  function automatic logic [PW-1:0] make_pz(input int seed);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < NPZ; i++) begin
      v[i*2*DW +: 2*DW] = {16'(seed * 7 + i), 16'(16'hA000 + seed + i * 3)};
    end
    return v;
  endfunction

  task automatic set_cfg(input int ore, input int oim, input int st, input int nz, input int np,
                         input int seed);
    cfg_origin_re = DW'(ore);
    cfg_origin_im = DW'(oim);
    cfg_step      = DW'(st);
    cfg_num_zeros = CW'(nz);
    cfg_num_poles = CW'(np);
    cfg_pz        = make_pz(seed);
  endtask

  task automatic push_frame(input int ore, input int oim, input int st);
    exp_t e;
    for (int y = 0; y < YS; y++) begin
      for (int x = 0; x < XS; x++) begin
        e.re   = model_coord(ore, x, st, 1'b0);
        e.im   = model_coord(oim, y, st, 1'b1);
        e.sof  = (x == 0 && y == 0);
        e.eol  = (x == XS - 1);
        e.last = (x == XS - 1 && y == YS - 1);
        sb.push_back(e);
      end
    end
  endtask

  // Runs until n transfers are seen, checking each against the scoreboard.
  // drop_at / upd_at: transfer index after which enable drops / cfg_update
  // pulses (0 = never).
  task automatic collect(input int n, input bit rnd, input int drop_at, input int upd_at);
    int            got = 0;
    int            cycles = 0;
    bit            fd_exp = 0;
    bit            en_at_end = 0;
    bit            b2b_exp = 0;
    bit            stalled = 0;
    logic [DW-1:0] s_re, s_im;
    logic          s_sof, s_eol;
    exp_t          e;
    while (got < n) begin
      @(negedge clk);
      cycles++;
      if (cycles > n * 4 + 40) begin
        n_checks++; n_fail++;
        $display("FAIL collect_timeout: got %0d transfers, required %0d", got, n);
        break;
      end
      n_checks++;
      if (frame_done !== fd_exp) begin
        n_fail++;
        $display("FAIL frame_done: got %b required %b at transfer %0d", frame_done, fd_exp, got);
      end
      if (b2b_exp) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back: out_valid %b required 1 after latch", out_valid);
        end
        b2b_exp = 0;
      end
      if (fd_exp) begin
        n_checks++;
        if (busy !== en_at_end) begin
          n_fail++;
          $display("FAIL busy_after_frame: got %b required %b", busy, en_at_end);
        end
        b2b_exp = en_at_end;
        fd_exp  = 0;
      end
      if (stalled) begin
        n_checks++;
        if (coord_re !== s_re || coord_im !== s_im || sof !== s_sof || eol !== s_eol ||
            out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: got re=%0h im=%0h sof=%b eol=%b v=%b required %0h %0h %b %b 1",
                   coord_re, coord_im, sof, eol, out_valid, s_re, s_im, s_sof, s_eol);
        end
      end
      cfg_update = 1'b0;
      out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL scoreboard_empty: got re=%0h im=%0h required no transfer",
                   coord_re, coord_im);
        end else begin
          e = sb.pop_front();
          n_checks++;
          if (coord_re !== e.re || coord_im !== e.im) begin
            n_fail++;
            $display("FAIL coord[%0d]: got (%0h,%0h) required (%0h,%0h)",
                     got, coord_re, coord_im, e.re, e.im);
          end
          n_checks++;
          if (sof !== e.sof || eol !== e.eol) begin
            n_fail++;
            $display("FAIL flags[%0d]: got sof=%b eol=%b required sof=%b eol=%b",
                     got, sof, eol, e.sof, e.eol);
          end
          got++;
          if (got == drop_at) enable = 1'b0;
          if (got == upd_at) cfg_update = 1'b1;
          if (e.last) begin
            fd_exp    = 1;
            en_at_end = enable;
          end
        end
      end
      stalled = out_valid && !out_ready;
      s_re = coord_re; s_im = coord_im; s_sof = sof; s_eol = eol;
    end
    @(negedge clk);
    cfg_update = 1'b0;
    out_ready  = 1'b1;
    n_checks++;
    if (frame_done !== fd_exp) begin
      n_fail++;
      $display("FAIL frame_done_tail: got %b required %b", frame_done, fd_exp);
    end
  endtask

  task automatic test_reset();
    set_cfg(-8, 8, 4, 3, 2, 1);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || sof !== 1'b0 ||
        eol !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%b busy=%b fd=%b sof=%b eol=%b required all 0",
               out_valid, busy, frame_done, sof, eol);
    end
    n_checks++;
    if (coord_re !== '0 || coord_im !== '0 || num_zeros_out !== '0 || num_poles_out !== '0 ||
        pz_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got re=%0h im=%0h nz=%0d np=%0d required 0",
               coord_re, coord_im, num_zeros_out, num_poles_out);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic_frame();
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_cycle: got busy=%b valid=%b required 1 0", busy, out_valid);
    end
    push_frame(-8, 8, 4);
    collect(XS * YS, 1'b0, 1, 0);
    n_checks++;
    if (num_zeros_out !== CW'(3) || num_poles_out !== CW'(2) || pz_out !== make_pz(1)) begin
      n_fail++;
      $display("FAIL first_latch: got nz=%0d np=%0d required 3 2 (pz match %b)",
               num_zeros_out, num_poles_out, pz_out === make_pz(1));
    end
  endtask

  task automatic test_stall();
    enable = 1'b1;
    push_frame(-8, 8, 4);
    collect(XS * YS, 1'b1, 3, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end_idle: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_cfg_update();
    set_cfg(100, 8, 4, 15, 5, 2);
    enable = 1'b1;
    push_frame(-8, 8, 4);
    push_frame(100, 8, 4);
    collect(2 * XS * YS, 1'b0, 20, 5);
    n_checks++;
    if (num_zeros_out !== CW'(8) || num_poles_out !== CW'(5)) begin
      n_fail++;
      $display("FAIL count_clamp: got nz=%0d np=%0d required 8 5", num_zeros_out, num_poles_out);
    end
    n_checks++;
    if (pz_out !== make_pz(2)) begin
      n_fail++;
      $display("FAIL pz_latch: got %h required %h", pz_out[63:0], make_pz(2) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_reset_mid_frame();
    enable = 1'b1;
    push_frame(100, 8, 4);
    collect(6, 1'b0, 0, 0);
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || coord_re !== '0 || num_zeros_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b busy=%b re=%0h nz=%0d required 0 0 0 0",
               out_valid, busy, coord_re, num_zeros_out);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL relatch: got busy=%b valid=%b required 1 0", busy, out_valid);
    end
    push_frame(100, 8, 4);
    collect(XS * YS, 1'b0, 1, 0);
    n_checks++;
    if (num_zeros_out !== CW'(8)) begin
      n_fail++;
      $display("FAIL relatch_cfg: got nz=%0d required 8", num_zeros_out);
    end
  endtask

  task automatic test_saturate();
    set_cfg(32760, -32760, 4, 1, 1, 3);
    cfg_update = 1'b1;
    @(negedge clk);
    cfg_update = 1'b0;
    enable     = 1'b1;
    push_frame(32760, -32760, 4);
    collect(XS * YS, 1'b1, 2, 0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_cfg_update();
    test_reset_mid_frame();
    test_saturate();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
